// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and helpers for the UART transmit controller.
// State encoding, data/frame bit counts and the parity helper used when
// the controller is built with UART_TX_PARITY_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int DATA_BITS        = 8;
    localparam int FRAME_BITS_NOPAR = 10;
    localparam int FRAME_BITS_PAR   = 11;

    // Parity bit for a byte: even sense makes the total count of ones even.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] b, input logic odd);
        return odd ? ~^b : ^b;
    endfunction

endpackage

// File: rtl/uart_tx_baud_tick.sv
// uart_tx_baud_tick: reloadable down-counter producing one tick every DIV+1
// enabled cycles. Held at DIV while disabled so every enabled run starts a
// full bit period. Tick is combinational from the count and enable.
module uart_tx_baud_tick #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] DIV   = 16'd10417
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic tick_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == '0);

    // Next count: reload on tick or while disabled, otherwise count down.
    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || tick_o) begin
            cnt_d = DIV;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register with synchronous active-low reset to the reload value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= DIV;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: one UART frame per accepted byte (start, 8 data LSB-first,
// optional parity, stop). Build macro UART_TX_PARITY_EN adds the parity bit
// and the PARITY_ODD parameter; without it the frame is 10 bits.
// All outputs are registered except tx_ready, decoded from the state register.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] DIV        = 16'd10417
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit               PARITY_ODD = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    uart_state_e          state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [2:0]           idx_q;
    logic                 tx_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 tick;
`ifdef UART_TX_PARITY_EN
    logic [DATA_BITS-1:0] byte_q;
`endif

    // The baud counter only runs while a frame is on the line.
    uart_tx_baud_tick #(
        .WIDTH (WIDTH),
        .DIV   (DIV)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q != ST_IDLE),
        .tick_o (tick)
    );

    assign tx_ready = (state_q == ST_IDLE);
    assign tx       = tx_q;
    assign busy     = busy_q;
    assign tx_done  = done_q;

    // Frame sequencer; tx_q is loaded with the level of the state being entered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            byte_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (tx_valid) begin
                        shift_q <= tx_data;
`ifdef UART_TX_PARITY_EN
                        byte_q  <= tx_data;
`endif
                        idx_q   <= '0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        tx_q    <= shift_q[0];
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shift_q <= shift_q >> 1;
                        idx_q   <= idx_q + 1'b1;
                        if (idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_bit(byte_q, PARITY_ODD);
                            state_q <= ST_PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
`endif
                        end else begin
                            tx_q <= shift_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
